// File: rtl/upstream_sched_pkg.sv
// Shared types and the round-robin pick helper for the upstream link scheduler.
package upstream_sched_pkg;

    localparam int LINK_W    = 32;
    localparam int PKT_W     = 64;
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    // First set bit of valid at or after ptr+1, wrapping modulo n; returns ptr when none is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (valid[idx[MAX_REQ_W-1:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/upstream_credit_ctr.sv
// Link credit counter: token-edge detect, saturating net add/sub and sticky overflow flag.
// UPSTREAM_LINK_SCHED_STATS_EN exposes the token edge for the statistics counter.
module upstream_credit_ctr
    import upstream_sched_pkg::*;
#(
    parameter int  CREDITS    = 16,
    parameter int  TOKEN_GRAN = 8,
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume_i,
    input  logic          token_toggle_i,
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
    output logic          tok_edge_o,
`endif
    output logic [CW-1:0] credits_o,
    output logic          err_o
);

    localparam int SW = CW + 2;
    localparam logic signed [SW-1:0] GRAN_S = SW'(TOKEN_GRAN);
    localparam logic signed [SW-1:0] MAX_S  = SW'(CREDITS);

    logic                 tok_q;
    logic                 tok_edge;
    logic [CW-1:0]        credits_q;
    logic [CW-1:0]        credits_d;
    logic                 err_q;
    logic                 err_d;
    logic signed [SW-1:0] sum;

    function automatic logic [CW-1:0] sat_credits(input logic signed [SW-1:0] v);
        if (v > MAX_S)    return CW'(CREDITS);
        else if (v[SW-1]) return '0;
        else              return v[CW-1:0];
    endfunction

    function automatic logic over_credits(input logic signed [SW-1:0] v);
        return v > MAX_S;
    endfunction

    always_comb begin
        tok_edge  = tok_q ^ token_toggle_i;
        sum       = $signed({2'b00, credits_q}) - $signed(SW'(consume_i))
                  + (tok_edge ? GRAN_S : '0);
        credits_d = sat_credits(sum);
        err_d     = err_q | over_credits(sum);
    end

    // tok_q follows the input through reset so the first post-reset cycle sees no false edge.
    always_ff @(posedge clk) begin
        tok_q <= token_toggle_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits_o = credits_q;
    assign err_o     = err_q;
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
    assign tok_edge_o = tok_edge & ~rst;
`endif

endmodule

// File: rtl/upstream_link_sched.sv
// Credit-gated round-robin scheduler sending 64-bit packets as two 32-bit link beats.
// UPSTREAM_LINK_SCHED_STATS_EN adds pkt_sent_o / tok_seen_o counters.
module upstream_link_sched
    import upstream_sched_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  CREDITS    = 16,
    parameter int  TOKEN_GRAN = 8,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CW         = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*PKT_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     token_toggle_i,
    output logic                     link_valid_o,
    output logic [LINK_W-1:0]        link_data_o,
    input  logic                     link_ready_i,
    output logic [CW-1:0]            credits_o,
    output logic [IDX_W-1:0]         grant_id_o,
    output logic                     credit_err_o
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
    ,
    output logic [31:0]              pkt_sent_o,
    output logic [31:0]              tok_seen_o
`endif
);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   grant_d;
    logic [IDX_W-1:0]   winner;
    logic [PKT_W-1:0]   pkt_q;
    logic [PKT_W-1:0]   sel_data;
    logic               can_accept;
    logic               accept;

    always_comb begin
        winner   = IDX_W'(rr_pick(MAX_REQ'(req_valid_i), int'(rr_ptr_q), NUM_REQ));
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) sel_data = req_data_i[i*PKT_W +: PKT_W];
        end
    end

    // Accept is combinational so the ready pulse and the consume happen in the same cycle.
    always_comb begin
        can_accept = !rst && (|req_valid_i) && (credits_o != '0);
        accept     = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            IDLE: begin
                accept  = can_accept;
                state_d = can_accept ? BEAT0 : IDLE;
            end
            BEAT0: begin
                if (link_ready_i) state_d = BEAT1;
            end
            BEAT1: begin
                if (link_ready_i) begin
                    accept  = can_accept;
                    state_d = can_accept ? BEAT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rr_ptr_d    = accept ? winner : rr_ptr_q;
        grant_d     = accept ? winner : grant_q;
        req_ready_o = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    end

    always_comb begin
        link_valid_o = (state_q != IDLE);
        unique case (state_q)
            BEAT0:   link_data_o = pkt_q[LINK_W-1:0];
            BEAT1:   link_data_o = pkt_q[PKT_W-1:LINK_W];
            default: link_data_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Packet payload carries no reset; link_data_o is forced to zero outside the beat states.
    always_ff @(posedge clk) begin
        if (accept) pkt_q <= sel_data;
    end

    assign grant_id_o = grant_q;

`ifdef UPSTREAM_LINK_SCHED_STATS_EN
    logic        tok_edge;
    logic [31:0] pkt_sent_q;
    logic [31:0] tok_seen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_sent_q <= '0;
            tok_seen_q <= '0;
        end else begin
            if (state_q == BEAT1 && link_ready_i) pkt_sent_q <= pkt_sent_q + 32'd1;
            if (tok_edge)                         tok_seen_q <= tok_seen_q + 32'd1;
        end
    end

    assign pkt_sent_o = pkt_sent_q;
    assign tok_seen_o = tok_seen_q;
`endif

    upstream_credit_ctr #(
        .CREDITS    (CREDITS),
        .TOKEN_GRAN (TOKEN_GRAN)
    ) u_credit (
        .clk            (clk),
        .rst            (rst),
        .consume_i      (accept),
        .token_toggle_i (token_toggle_i),
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
        .tok_edge_o     (tok_edge),
`endif
        .credits_o      (credits_o),
        .err_o          (credit_err_o)
    );

endmodule

// File: tb/tb_upstream_link_sched.sv
// Self-checking bench for upstream_link_sched: transaction-level model plus directed literal checks.
module tb_upstream_link_sched;

    localparam int N    = 4;
    localparam int CRED = 16;
    localparam int GRAN = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid_i;
    logic [N*64-1:0] req_data_i;
    logic [N-1:0]    req_ready_o;
    logic            token_toggle_i;
    logic            link_valid_o;
    logic [31:0]     link_data_o;
    logic            link_ready_i;
    logic [4:0]      credits_o;
    logic [1:0]      grant_id_o;
    logic            credit_err_o;
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
    logic [31:0]     pkt_sent_o;
    logic [31:0]     tok_seen_o;
`endif

    always #5 clk = ~clk;

    upstream_link_sched #(
        .NUM_REQ    (N),
        .CREDITS    (CRED),
        .TOKEN_GRAN (GRAN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .token_toggle_i (token_toggle_i),
        .link_valid_o   (link_valid_o),
        .link_data_o    (link_data_o),
        .link_ready_i   (link_ready_i),
        .credits_o      (credits_o),
        .grant_id_o     (grant_id_o),
        .credit_err_o   (credit_err_o)
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
        ,
        .pkt_sent_o     (pkt_sent_o),
        .tok_seen_o     (tok_seen_o)
`endif
    );

    // Model: credits, beats still owed for the packet in flight, RR pointer, last grant.
    int          m_cred;
    bit          m_err;
    int          m_beats;
    logic [63:0] m_pkt;
    int          m_ptr;
    int          m_grant;
    logic        m_tok;
    logic [31:0] m_pkts;
    logic [31:0] m_toks;

    // Requester side: a packet stays pending until the model says it was taken.
    bit          pend [N];
    logic [63:0] pdat [N];
    int          refill_pct;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cred  = CRED;
        m_err   = 1'b0;
        m_beats = 0;
        m_ptr   = N - 1;
        m_grant = 0;
        m_pkts  = '0;
        m_toks  = '0;
    endtask

    // Called #1 after a posedge with rst/token/ready already set; checks then advances the model.
    task automatic cycle();
        bit          acc;
        bit          edge_seen;
        int          w;
        int          nxt;
        logic [N-1:0] exp_rdy;
        logic [31:0] exp_data;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < refill_pct) begin
                pend[i] = 1'b1;
                pdat[i] = {$urandom, $urandom};
            end
            req_valid_i[i]         = pend[i];
            req_data_i[i*64 +: 64] = pdat[i];
        end
        #1;
        acc = !rst && (|req_valid_i) && m_cred > 0 &&
              (m_beats == 0 || (m_beats == 1 && link_ready_i));
        w = -1;
        if (acc) begin
            for (int k = 1; k <= N; k++) begin
                if (w < 0 && req_valid_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_rdy  = acc ? N'(1) << w : '0;
        exp_data = (m_beats == 2) ? m_pkt[31:0] : (m_beats == 1) ? m_pkt[63:32] : 32'd0;
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("link_valid", 64'(link_valid_o), 64'(m_beats != 0));
        chk("link_data", 64'(link_data_o), 64'(exp_data));
        chk("credits", 64'(credits_o), 64'(m_cred));
        chk("grant_id", 64'(grant_id_o), 64'(m_grant));
        chk("credit_err", 64'(credit_err_o), 64'(m_err));
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
        chk("pkt_sent", 64'(pkt_sent_o), 64'(m_pkts));
        chk("tok_seen", 64'(tok_seen_o), 64'(m_toks));
`endif
        edge_seen = (token_toggle_i !== m_tok);
        m_tok     = token_toggle_i;
        if (rst) begin
            model_reset();
        end else begin
            if (m_beats == 1 && link_ready_i) m_pkts = m_pkts + 32'd1;
            if (edge_seen) m_toks = m_toks + 32'd1;
            if (m_beats > 0 && link_ready_i) m_beats--;
            if (acc) begin
                m_beats = 2;
                m_pkt   = pdat[w];
                m_ptr   = w;
                m_grant = w;
                pend[w] = 1'b0;
            end
            nxt = m_cred - int'(acc) + (edge_seen ? GRAN : 0);
            if (nxt > CRED) begin
                nxt   = CRED;
                m_err = 1'b1;
            end
            m_cred = nxt;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        refill_pct = 0;
        rst = 1'b1;
        cycle();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lo;
        int          b;
        rst            = 1'b1;
        token_toggle_i = 1'b0;
        link_ready_i   = 1'b0;
        req_valid_i    = '0;
        req_data_i     = '0;
        refill_pct     = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
        end
        m_tok = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        cycle();
        chk("rst_credits", 64'(credits_o), 64'd16);
        chk("rst_link_valid", 64'(link_valid_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_err", 64'(credit_err_o), 64'd0);
        adv();
        rst = 1'b0;

        // 1: single packet from requester 0
        link_ready_i = 1'b1;
        pend[0] = 1'b1;
        pdat[0] = 64'h1122334455667788;
        cycle();
        chk("t1_ready_pulse", 64'(req_ready_o), 64'h1);
        adv();
        cycle();
        chk("t1_beat0", 64'(link_data_o), 64'h55667788);
        chk("t1_credits", 64'(credits_o), 64'd15);
        adv();
        cycle();
        chk("t1_beat1", 64'(link_data_o), 64'h11223344);
        adv();
        cycle();
        chk("t1_idle", 64'(link_valid_o), 64'd0);
        adv();

        // 2: all requesters busy, grants rotate 0,1,2,3,0 with no bubble
        do_reset();
        refill_pct = 100;
        link_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t2_rr_ready", 64'(req_ready_o), (k % 2 == 0) ? 64'(1 << ((k / 2) % 4)) : 64'd0);
            if (k % 2 == 1) chk("t2_grant", 64'(grant_id_o), 64'((k / 2) % 4));
            if (k >= 1) chk("t2_no_bubble", 64'(link_valid_o), 64'd1);
            adv();
        end
        for (int k = 0; k < 40; k++) begin
            if (k % 16 == 15) token_toggle_i = ~token_toggle_i;
            cycle();
            chk("t2_stream", 64'(link_valid_o), 64'd1);
            adv();
        end

        // 3: credits run out without tokens, one toggle resumes
        do_reset();
        refill_pct = 100;
        for (int k = 0; k < 40; k++) begin
            cycle();
            adv();
        end
        cycle();
        chk("t3_credits0", 64'(credits_o), 64'd0);
        chk("t3_no_ready", 64'(req_ready_o), 64'd0);
        chk("t3_no_valid", 64'(link_valid_o), 64'd0);
        adv();
        token_toggle_i = ~token_toggle_i;
        cycle();
        adv();
        cycle();
        chk("t3_credits8", 64'(credits_o), 64'd8);
        chk("t3_resume", 64'(req_ready_o != '0), 64'd1);
        adv();

        // 4: accept and token return in the same cycle; overflow at full credits
        do_reset();
        refill_pct = 100;
        b = 0;
        while (!(m_cred == 5 && m_beats != 2) && b < 100) begin
            cycle();
            adv();
            b++;
        end
        chk("t4_reach_5", 64'(b < 100), 64'd1);
        token_toggle_i = ~token_toggle_i;
        cycle();
        chk("t4_accept", 64'(req_ready_o != '0), 64'd1);
        chk("t4_credits5", 64'(credits_o), 64'd5);
        adv();
        cycle();
        chk("t4_credits12", 64'(credits_o), 64'd12);
        adv();
        do_reset();
        token_toggle_i = ~token_toggle_i;
        cycle();
        adv();
        cycle();
        chk("t4_sat16", 64'(credits_o), 64'd16);
        chk("t4_err", 64'(credit_err_o), 64'd1);
        adv();

        // 5: link stalls for 3 cycles in BEAT0
        do_reset();
        link_ready_i = 1'b1;
        pend[0] = 1'b1;
        pdat[0] = {$urandom, $urandom};
        lo = pdat[0][31:0];
        cycle();
        adv();
        pend[0] = 1'b1;
        pdat[0] = {$urandom, $urandom};
        link_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_hold_data", 64'(link_data_o), 64'(lo));
            chk("t5_hold_valid", 64'(link_valid_o), 64'd1);
            chk("t5_no_ready", 64'(req_ready_o), 64'd0);
            adv();
        end
        link_ready_i = 1'b1;
        cycle();
        chk("t5_release", 64'(link_data_o), 64'(lo));
        adv();
        for (int k = 0; k < 4; k++) begin
            cycle();
            adv();
        end

        // 6: reset during BEAT1 drops the packet; requester 0 wins afterwards
        do_reset();
        link_ready_i = 1'b1;
        pend[0] = 1'b1;
        pdat[0] = {$urandom, $urandom};
        cycle();
        adv();
        cycle();
        adv();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pdat[i] = {$urandom, $urandom};
        end
        rst = 1'b1;
        cycle();
        adv();
        rst = 1'b0;
        cycle();
        chk("t6_valid0", 64'(link_valid_o), 64'd0);
        chk("t6_credits16", 64'(credits_o), 64'd16);
        chk("t6_req0_wins", 64'(req_ready_o), 64'h1);
        adv();

        // Random traffic, stalls, tokens and occasional resets
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            refill_pct     = (k < 1500) ? 50 : 25;
            link_ready_i   = ($urandom_range(9) < 7);
            if ($urandom_range(11) == 0) token_toggle_i = ~token_toggle_i;
            rst            = ($urandom_range(399) == 0);
            cycle();
            adv();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
